obi_arbiter_2_to_1: RTL and testbench



---
 rtl/obi_pkg.sv | 20 ++
 rtl/obi_id_fifo.sv | 63 ++++++
 rtl/obi_arbiter_2_to_1.sv | 103 ++++++++++
 tb/tb_obi_arbiter_2_to_1.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/obi_pkg.sv
// Shared OBI field widths, master ID type and the bundled address-phase request.
package obi_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BE_W   = 4;

   typedef logic obi_mid_t;

   localparam obi_mid_t MID_M0 = 1'b0;
   localparam obi_mid_t MID_M1 = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              we;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wdata;
   } obi_req_t;

endpackage

// File: rtl/obi_id_fifo.sv
// Small FIFO of master IDs for accepted reads; the head is readable combinationally
// so responses can be steered in the same cycle they arrive.
module obi_id_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign pop_ok  = pop && !empty;
   // A pop in the same cycle frees the slot the push lands in.
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem[rd_ptr_reg];

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
               mem[gi] <= push_data;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) wr_ptr_reg <= next_ptr(wr_ptr_reg);
         if (pop_ok)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/obi_arbiter_2_to_1.sv
// Two-master OBI arbiter: round-robin selection held until grant, with an ID FIFO
// steering read responses back to the issuing master in order.
module obi_arbiter_2_to_1
   import obi_pkg::*;
#(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              m0_req_i,
   output logic              m0_gnt_o,
   input  logic [ADDR_W-1:0] m0_addr_i,
   input  logic              m0_we_i,
   input  logic [BE_W-1:0]   m0_be_i,
   input  logic [DATA_W-1:0] m0_wdata_i,
   output logic              m0_rvalid_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   output logic              m1_gnt_o,
   input  logic [ADDR_W-1:0] m1_addr_i,
   input  logic              m1_we_i,
   input  logic [BE_W-1:0]   m1_be_i,
   input  logic [DATA_W-1:0] m1_wdata_i,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              s_req_o,
   input  logic              s_gnt_i,
   output logic [ADDR_W-1:0] s_addr_o,
   output logic              s_we_o,
   output logic [BE_W-1:0]   s_be_o,
   output logic [DATA_W-1:0] s_wdata_o,
   input  logic              s_rvalid_i,
   input  logic [DATA_W-1:0] s_rdata_i,
   output logic              err_o
);

   obi_mid_t sel;
   obi_mid_t last_reg, lock_mid_reg, fifo_head;
   logic     lock_reg;
   logic     sel_req, grant, push, pop, fifo_full, fifo_empty, blocked;
   obi_req_t m0_fields, m1_fields, s_fields;

   assign m0_fields = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
   assign m1_fields = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};

   always_comb begin
      sel = MID_M0;
      if (lock_reg)                  sel = lock_mid_reg;
      else if (m0_req_i && m1_req_i) sel = ~last_reg;
      else if (m1_req_i)             sel = MID_M1;
   end

   assign s_fields  = (sel == MID_M1) ? m1_fields : m0_fields;
   assign s_addr_o  = s_fields.addr;
   assign s_we_o    = s_fields.we;
   assign s_be_o    = s_fields.be;
   assign s_wdata_o = s_fields.wdata;

   assign sel_req = (sel == MID_M1) ? m1_req_i : m0_req_i;
   assign pop     = s_rvalid_i && !fifo_empty;
   assign blocked = fifo_full && !pop;
   // Gated by reset so the address phase reads idle while reset is held.
   assign s_req_o  = !rst_i && sel_req && !blocked;
   assign grant    = s_req_o && s_gnt_i;
   assign m0_gnt_o = grant && (sel == MID_M0);
   assign m1_gnt_o = grant && (sel == MID_M1);
   assign push     = grant && !s_we_o;

   assign m0_rvalid_o = pop && (fifo_head == MID_M0);
   assign m1_rvalid_o = pop && (fifo_head == MID_M1);
   assign m0_rdata_o  = s_rdata_i;
   assign m1_rdata_o  = s_rdata_i;
   assign err_o       = !rst_i && s_rvalid_i && fifo_empty;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_reg     <= 1'b0;
         lock_mid_reg <= MID_M0;
         last_reg     <= MID_M1;
      end else if (grant) begin
         lock_reg <= 1'b0;
         last_reg <= sel;
      end else if (s_req_o) begin
         lock_reg     <= 1'b1;
         lock_mid_reg <= sel;
      end
   end

   obi_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (1)
   ) u_id_fifo (
      .clk       (clk_i),
      .rst       (rst_i),
      .push      (push),
      .push_data (sel),
      .pop       (pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_obi_arbiter_2_to_1.sv
// Directed bench for the 2:1 OBI arbiter: selection, lock, full blocking, writes, errors, reset.
module tb_obi_arbiter_2_to_1;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        m0_req_i, m0_gnt_o, m0_we_i, m0_rvalid_o;
   logic [31:0] m0_addr_i, m0_wdata_i, m0_rdata_o;
   logic [3:0]  m0_be_i;
   logic        m1_req_i, m1_gnt_o, m1_we_i, m1_rvalid_o;
   logic [31:0] m1_addr_i, m1_wdata_i, m1_rdata_o;
   logic [3:0]  m1_be_i;
   logic        s_req_o, s_gnt_i, s_we_o, s_rvalid_i, err_o;
   logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
   logic [3:0]  s_be_o;

   int checks = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   obi_arbiter_2_to_1 #(.MAX_OUTSTANDING(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
      .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
      .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
      .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
      .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o),
      .s_be_o(s_be_o), .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
      .err_o(err_o)
   );

   // Inputs change 1 time unit after a rising edge; checks happen 3 units later.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      m0_req_i = 0; m0_we_i = 0; m0_be_i = 4'hF; m0_addr_i = 32'h2000; m0_wdata_i = 0;
      m1_req_i = 0; m1_we_i = 0; m1_be_i = 4'hF; m1_addr_i = 32'h3000; m1_wdata_i = 0;
      s_gnt_i = 0; s_rvalid_i = 0; s_rdata_i = 0;
   endtask

   task automatic do_reset();
      idle();
      rst_i = 1;
      step();
      rst_i = 0;
   endtask

   task automatic test_reset();
      idle();
      rst_i = 1;
      m0_req_i = 1; m1_req_i = 1; s_gnt_i = 1; s_rvalid_i = 1;
      #3;
      checks++; if (s_req_o !== 1'b0) begin failures++; $display("FAIL reset_s_req got=%b exp=0", s_req_o); end
      checks++; if ({m0_gnt_o, m1_gnt_o} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", {m0_gnt_o, m1_gnt_o}); end
      checks++; if ({m0_rvalid_o, m1_rvalid_o, err_o} !== 3'b000) begin failures++; $display("FAIL reset_rvalid_err got=%b exp=000", {m0_rvalid_o, m1_rvalid_o, err_o}); end
      $display("test_reset: outputs idle under reset");
      step();
      rst_i = 0;
      idle();
   endtask

   task automatic test_single();
      do_reset();
      m0_req_i = 1; m0_addr_i = 32'h1000; s_gnt_i = 1;
      #3;
      checks++; if ({s_req_o, m0_gnt_o, m1_gnt_o} !== 3'b110) begin failures++; $display("FAIL single_gnt got=%b exp=110", {s_req_o, m0_gnt_o, m1_gnt_o}); end
      checks++; if (s_addr_o !== 32'h1000) begin failures++; $display("FAIL single_addr got=%h exp=00001000", s_addr_o); end
      step();
      idle();
      s_rvalid_i = 1; s_rdata_i = 32'hCAFEF00D;
      #3;
      checks++; if ({m0_rvalid_o, m1_rvalid_o, err_o} !== 3'b100) begin failures++; $display("FAIL single_rvalid got=%b exp=100", {m0_rvalid_o, m1_rvalid_o, err_o}); end
      checks++; if (m0_rdata_o !== 32'hCAFEF00D || m1_rdata_o !== 32'hCAFEF00D) begin failures++; $display("FAIL single_rdata got=%h/%h exp=cafef00d", m0_rdata_o, m1_rdata_o); end
      $display("test_single: m0 read 0x1000 -> rdata %h", m0_rdata_o);
      step();
      idle();
   endtask

   task automatic test_round_robin();
      bit e_g0 [5] = '{1, 0, 1, 0, 0};
      bit e_g1 [5] = '{0, 1, 0, 1, 0};
      bit e_r0 [5] = '{0, 1, 0, 1, 0};
      bit e_r1 [5] = '{0, 0, 1, 0, 1};
      do_reset();
      for (int c = 0; c < 5; c++) begin
         m0_req_i = (c < 4); m1_req_i = (c < 4); s_gnt_i = 1;
         s_rvalid_i = (c > 0); s_rdata_i = 32'hA000_0000 + c;
         #3;
         checks++; if ({m0_gnt_o, m1_gnt_o} !== {e_g0[c], e_g1[c]}) begin failures++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, {m0_gnt_o, m1_gnt_o}, {e_g0[c], e_g1[c]}); end
         checks++; if ({m0_rvalid_o, m1_rvalid_o} !== {e_r0[c], e_r1[c]}) begin failures++; $display("FAIL rr_rvalid c=%0d got=%b exp=%b", c, {m0_rvalid_o, m1_rvalid_o}, {e_r0[c], e_r1[c]}); end
         if (c < 4) begin
            checks++; if (s_addr_o !== (e_g0[c] ? 32'h2000 : 32'h3000)) begin failures++; $display("FAIL rr_addr c=%0d got=%h", c, s_addr_o); end
         end
         $display("test_round_robin: cycle %0d gnt=%b rvalid=%b", c, {m0_gnt_o, m1_gnt_o}, {m0_rvalid_o, m1_rvalid_o});
         step();
      end
      idle();
   endtask

   task automatic test_lock();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         m1_req_i = 1; m0_req_i = (c > 0); s_gnt_i = 0;
         #3;
         checks++; if (s_addr_o !== 32'h3000 || s_req_o !== 1'b1) begin failures++; $display("FAIL lock_addr c=%0d got=%h req=%b exp=00003000/1", c, s_addr_o, s_req_o); end
         checks++; if (m0_gnt_o !== 1'b0) begin failures++; $display("FAIL lock_m0_gnt c=%0d got=%b exp=0", c, m0_gnt_o); end
         $display("test_lock: cycle %0d s_addr=%h", c, s_addr_o);
         step();
      end
      s_gnt_i = 1;
      #3;
      checks++; if ({m0_gnt_o, m1_gnt_o} !== 2'b01) begin failures++; $display("FAIL lock_release got=%b exp=01", {m0_gnt_o, m1_gnt_o}); end
      step();
      m1_req_i = 0;
      #3;
      checks++; if ({m0_gnt_o, m1_gnt_o} !== 2'b10 || s_addr_o !== 32'h2000) begin failures++; $display("FAIL lock_next got=%b/%h exp=10/00002000", {m0_gnt_o, m1_gnt_o}, s_addr_o); end
      step();
      idle();
      s_rvalid_i = 1;
      #3;
      checks++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b01) begin failures++; $display("FAIL lock_resp1 got=%b exp=01", {m0_rvalid_o, m1_rvalid_o}); end
      step();
      #3;
      checks++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b10) begin failures++; $display("FAIL lock_resp2 got=%b exp=10", {m0_rvalid_o, m1_rvalid_o}); end
      step();
      idle();
   endtask

   task automatic test_full_and_error();
      do_reset();
      m0_req_i = 1; s_gnt_i = 1;
      step();
      m0_req_i = 0; m1_req_i = 1;
      step();
      m1_req_i = 0; m0_req_i = 1;
      #3;
      checks++; if ({s_req_o, m0_gnt_o} !== 2'b00) begin failures++; $display("FAIL full_block got=%b exp=00", {s_req_o, m0_gnt_o}); end
      step();
      s_rvalid_i = 1; s_rdata_i = 32'h1111_2222;
      #3;
      checks++; if ({s_req_o, m0_gnt_o} !== 2'b11) begin failures++; $display("FAIL full_pop_grant got=%b exp=11", {s_req_o, m0_gnt_o}); end
      checks++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b10) begin failures++; $display("FAIL full_pop_rvalid got=%b exp=10", {m0_rvalid_o, m1_rvalid_o}); end
      step();
      m0_req_i = 0; s_gnt_i = 0;
      #3;
      checks++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b01) begin failures++; $display("FAIL full_drain1 got=%b exp=01", {m0_rvalid_o, m1_rvalid_o}); end
      step();
      #3;
      checks++; if ({m0_rvalid_o, m1_rvalid_o, err_o} !== 3'b100) begin failures++; $display("FAIL full_drain2 got=%b exp=100", {m0_rvalid_o, m1_rvalid_o, err_o}); end
      step();
      #3;
      checks++; if ({m0_rvalid_o, m1_rvalid_o, err_o} !== 3'b001) begin failures++; $display("FAIL err_pulse got=%b exp=001", {m0_rvalid_o, m1_rvalid_o, err_o}); end
      step();
      s_rvalid_i = 0;
      #3;
      checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", err_o); end
      $display("test_full_and_error: blocking, same-cycle pop and error pulse done");
      step();
      idle();
   endtask

   task automatic test_write();
      do_reset();
      m0_req_i = 1; m0_we_i = 1; m0_addr_i = 32'h4000; m0_wdata_i = 32'hDEADBEEF; m0_be_i = 4'h3; s_gnt_i = 1;
      #3;
      checks++; if ({m0_gnt_o, s_we_o, s_be_o} !== 6'b11_0011 || s_wdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL write_fields got=%b/%h exp=110011/deadbeef", {m0_gnt_o, s_we_o, s_be_o}, s_wdata_o); end
      step();
      idle();
      m1_req_i = 1; s_gnt_i = 1;
      #3;
      checks++; if ({m0_gnt_o, m1_gnt_o} !== 2'b01) begin failures++; $display("FAIL write_m1_gnt got=%b exp=01", {m0_gnt_o, m1_gnt_o}); end
      step();
      idle();
      s_rvalid_i = 1;
      #3;
      checks++; if ({m0_rvalid_o, m1_rvalid_o, err_o} !== 3'b010) begin failures++; $display("FAIL write_resp got=%b exp=010", {m0_rvalid_o, m1_rvalid_o, err_o}); end
      step();
      #3;
      checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL write_no_id got=%b exp=1", err_o); end
      $display("test_write: write left no ID, m1 read answered");
      step();
      idle();
   endtask

   task automatic test_reset_midflight();
      do_reset();
      m0_req_i = 1; s_gnt_i = 1;
      step();
      m0_req_i = 0; m1_req_i = 1;
      step();
      m1_req_i = 0; m0_req_i = 1; s_rvalid_i = 1;
      rst_i = 1;
      #1;
      checks++; if ({s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, err_o} !== 6'b0) begin failures++; $display("FAIL midreset_async got=%b exp=000000", {s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, err_o}); end
      step();
      rst_i = 0; m0_req_i = 0; s_gnt_i = 0;
      #3;
      checks++; if ({m0_rvalid_o, m1_rvalid_o, err_o} !== 3'b001) begin failures++; $display("FAIL midreset_err got=%b exp=001", {m0_rvalid_o, m1_rvalid_o, err_o}); end
      $display("test_reset_midflight: outstanding IDs discarded");
      step();
      idle();
   endtask

   initial begin
      idle();
      rst_i = 1;
      step();
      test_reset();
      test_single();
      test_round_robin();
      test_lock();
      test_full_and_error();
      test_write();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
